// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
// Holds the byte width and the transmitter state encoding.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts CLKS_PER_BIT clocks per serial bit.
// bit_done is high on the last clock of every bit period.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == LAST);

  // Free-running bit-period counter, wraps at LAST, held at 0 by clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and shifts them out as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              txd,
  output logic              busy
);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              bit_done;
  logic              load;
  logic              baud_clr;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign load = !reset && !fifo_empty &&
                ((state == IDLE) ||
                 ((state == STOP) && bit_done));

  assign fifo_rd  = load;
  assign baud_clr = load || (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clr),
    .bit_done (bit_done)
  );

  // Frame sequencer: loads a byte, then walks start/data/(parity)/stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (load) begin
      state   <= START;
      txd     <= 1'b0;
      busy    <= 1'b1;
      shreg   <= fifo_dout;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= ^fifo_dout;
`endif
    end else if (bit_done) begin
      unique case (state)
        START: begin
          state <= DATA;
          txd   <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: begin
          if (bit_cnt == 3'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            txd   <= par;
`else
            state <= STOP;
            txd   <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          txd   <= 1'b1;
        end
`endif
        STOP: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed frame table plus randomized traffic,
// checked cycle by cycle against a frame-level line model.
module tb_fifo_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * N;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic       txd;
  logic       busy;

  logic [7:0] q[$];
  vec_t       tbl[5];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rd_count = 0;
  int  last_rd_cyc = 0;
  int  prev_rd_cyc = 0;
  bit  mon_en = 1'b0;

  logic       m_act = 1'b0;
  int         m_k = 0;
  logic [7:0] m_d = 8'h00;

  fifo_uart_tx #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .txd        (txd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
    fifo_dout  = q[0];
  endtask

  // Line level of bit slot b in the frame carrying byte d.
  function automatic logic fbit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // FIFO model: pop the head just after an edge that saw fifo_rd.
  initial begin
    forever begin
      @(posedge clk);
      if (fifo_rd === 1'b1) begin
        #1;
        if (q.size() != 0) void'(q.pop_front());
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
      end
    end
  end

  // Frame-level reference: a frame is F cycles; a new one may start
  // when idle or on the last cycle of the current one.
  initial begin
    logic       pr, pe, prd, ld;
    logic [7:0] pd;
    forever begin
      @(posedge clk);
      pr  = reset;
      pe  = fifo_empty;
      pd  = fifo_dout;
      prd = fifo_rd;
      cyc++;
      ld = !pr && !pe && (!m_act || (m_k == F - 1));
      if (mon_en) check("fifo_rd", prd, ld);
      if (prd === 1'b1) begin
        rd_count++;
        prev_rd_cyc = last_rd_cyc;
        last_rd_cyc = cyc;
      end
      if (pr) begin
        m_act = 1'b0;
      end else if (ld) begin
        m_act = 1'b1;
        m_k   = 0;
        m_d   = pd;
      end else if (m_act) begin
        m_k++;
        if (m_k == F) m_act = 1'b0;
      end
      #1;
      if (mon_en) begin
        check("txd", txd, m_act ? fbit(m_d, m_k / N) : 1'b1);
        check("busy", busy, m_act);
      end
    end
  end

  task automatic wait_rd(input string nm, input int bound);
    int s;
    int n;
    s = rd_count;
    n = 0;
    while (rd_count == s && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_count == s) begin
      errors++;
      $display("FAIL %s: got no fifo_rd in %0d cycles expected one", nm, bound);
    end
  endtask

  // Called on the negedge right after the load edge (frame cycle 0).
  task automatic check_frame(input vec_t v);
    repeat (N / 2) @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("frame_%02h_bit%0d", v.data, b), txd, v.frame[NB-1-b]);
      if (b < NB - 1) repeat (N) @(negedge clk);
      else repeat (N / 2 - 1) @(negedge clk);
    end
    check($sformatf("frame_%02h_busy_last", v.data), busy, 1'b1);
    @(negedge clk);
    check($sformatf("frame_%02h_busy_end", v.data), busy, 1'b0);
    check($sformatf("frame_%02h_txd_end", v.data), txd, 1'b1);
  endtask

  task automatic send_check(input vec_t v);
    push(v.data);
    wait_rd($sformatf("rd_%02h", v.data), 4);
    check_frame(v);
  endtask

  initial begin
    int idle_bad;
    int bound;
    int rs;
    int gap;

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b0_10100101_0_1};
    tbl[1] = '{8'h3C, 11'b0_00111100_0_1};
    tbl[2] = '{8'h96, 11'b0_01101001_0_1};
    tbl[3] = '{8'h07, 11'b0_11100000_1_1};
    tbl[4] = '{8'h03, 11'b0_11000000_0_1};
`else
    tbl[0] = '{8'hA5, 11'b0_0_10100101_1};
    tbl[1] = '{8'h3C, 11'b0_0_00111100_1};
    tbl[2] = '{8'h96, 11'b0_0_01101001_1};
    tbl[3] = '{8'h07, 11'b0_0_11100000_1};
    tbl[4] = '{8'h03, 11'b0_0_11000000_1};
`endif

    reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rd", fifo_rd, 1'b0);
    reset = 1'b0;

    idle_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) idle_bad++;
    end
    check_int("idle_200_bad_cycles", idle_bad, 0);

    for (int i = 0; i < 5; i++) send_check(tbl[i]);

    push(8'h00);
    push(8'hFF);
    wait_rd("b2b_first", 4);
    wait_rd("b2b_second", F + 4);
    check_int("b2b_rd_gap", last_rd_cyc - prev_rd_cyc, F);
    @(negedge clk);
    check("b2b_txd_start", txd, 1'b0);
    repeat (F + 2) @(negedge clk);

    push(8'h5A);
    wait_rd("stop_push_first", 4);
    repeat ((NB - 1) * N + 1) @(negedge clk);
    check("stop_push_pending_rd", fifo_rd, 1'b0);
    push(8'hC3);
    wait_rd("stop_push_second", F);
    check_int("stop_push_rd_gap", last_rd_cyc - prev_rd_cyc, F);
    repeat (F + 2) @(negedge clk);

    push(8'h3C);
    wait_rd("abort_load", 4);
    repeat (4 * N + 1) @(negedge clk);
    push(tbl[2].data);
    rs = rd_count;
    @(negedge clk);
    check_int("midframe_no_pop", rd_count, rs);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_rd("after_abort", 4);
    check_frame(tbl[2]);

    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3)) push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 3 * F)) @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
    end

    bound = (q.size() + 2) * F;
    gap = 0;
    while ((q.size() != 0 || busy !== 1'b0) && gap < bound) begin
      @(negedge clk);
      gap++;
    end
    check_int("drain_queue_left", q.size(), 0);
    check("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
